// File: rtl/axistream_snooper_pkg.sv
// Shared snooper definitions: FSM state encoding and a constant-safe ceil(log2) helper.
// The helper is also used by the snooper-side width adapter.
package axistream_snooper_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } sn_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axistream_snooper_if.sv
// AXI-Stream link bundle; the snooper attaches through the all-input monitor view.
interface axistream_snooper_if #(
   parameter int SN_WIDTH = 32
);
   logic [SN_WIDTH-1:0]   TDATA;
   logic [SN_WIDTH/8-1:0] TKEEP;
   logic                  TLAST;
   logic                  TVALID;
   logic                  TREADY;

   modport master  (output TDATA, TKEEP, TLAST, TVALID, input  TREADY);
   modport slave   (input  TDATA, TKEEP, TLAST, TVALID, output TREADY);
   modport monitor (input  TDATA, TKEEP, TLAST, TVALID, TREADY);
endinterface

// File: rtl/axistream_snooper_keep_popcount.sv
// Combinational TKEEP byte count, reduced modulo bytes-per-word (a full word reads as 0).
// Zero latency; no flow control.
module keep_popcount #(
   parameter int SN_WIDTH  = 32,
   parameter int INC_WIDTH = 2
) (
   input  logic [SN_WIDTH/8-1:0] keep_i,
   output logic [INC_WIDTH-1:0]  count_o
);
   logic [INC_WIDTH:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < SN_WIDTH/8; i++) begin
         sum = sum + (INC_WIDTH+1)'(keep_i[i]);
      end
   end

   assign count_o = sum[INC_WIDTH-1:0];
endmodule

// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap copying packets into the packet buffer; writes appear one cycle after
// each accepted beat. Never back-pressures: whole packets drop when no buffer is free at SOP.
module axistream_snooper
   import axistream_snooper_pkg::*;
#(
   parameter int SN_WIDTH       = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int INC_WIDTH      = clog2(SN_WIDTH/8),
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   axistream_snooper_if.monitor      snoop,
   input  logic                      rdy_for_sn,
   output logic [ADDR_WIDTH-1:0]     sn_addr,
   output logic [SN_WIDTH-1:0]       sn_wr_data,
   output logic                      sn_wr_en,
   output logic [INC_WIDTH-1:0]      sn_byte_inc,
   output logic                      sn_done,
   output logic                      packet_dropped,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
   sn_state_t                 state_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ADDR_WIDTH-1:0]     addr_d;
   logic [SN_WIDTH-1:0]       wr_data_q;
   logic                      wr_en_q;
   logic [INC_WIDTH-1:0]      byte_inc_q;
   logic                      done_q;
   logic                      dropped_q;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
   logic [INC_WIDTH-1:0]      keep_cnt;
   logic                      beat;

   keep_popcount #(
      .SN_WIDTH  (SN_WIDTH),
      .INC_WIDTH (INC_WIDTH)
   ) u_keep_popcount (
      .keep_i  (snoop.TKEEP),
      .count_o (keep_cnt)
   );

   assign beat   = snoop.TVALID & snoop.TREADY;
   assign addr_d = addr_q + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         byte_inc_q <= '0;
         done_q     <= 1'b0;
         dropped_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
         case (state_q)
            IDLE: if (beat) begin
               // done_q high means a buffer was just handed off and rdy_for_sn is still stale
               if (rdy_for_sn && !done_q) begin
                  addr_q     <= '0;
                  wr_data_q  <= snoop.TDATA;
                  wr_en_q    <= 1'b1;
                  byte_inc_q <= keep_cnt;
                  done_q     <= snoop.TLAST;
                  state_q    <= snoop.TLAST ? IDLE : WRITE;
               end else begin
                  dropped_q  <= 1'b1;
                  if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                  state_q    <= snoop.TLAST ? IDLE : DROP;
               end
            end
            WRITE: if (beat) begin
               addr_q     <= addr_d;
               wr_data_q  <= snoop.TDATA;
               wr_en_q    <= 1'b1;
               byte_inc_q <= keep_cnt;
               if (snoop.TLAST) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (addr_d == '1) begin
                  // Buffer full: close it out as a full word and discard the remainder
                  done_q     <= 1'b1;
                  byte_inc_q <= '0;
                  state_q    <= DROP;
               end
            end
            DROP: if (beat && snoop.TLAST) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sn_addr        = addr_q;
   assign sn_wr_data     = wr_data_q;
   assign sn_wr_en       = wr_en_q;
   assign sn_byte_inc    = byte_inc_q;
   assign sn_done        = done_q;
   assign packet_dropped = dropped_q;
   assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_axistream_snooper.sv
// Directed bench for axistream_snooper with a 3-bit address (8-word buffer) and a 2-bit drop counter.
module tb_axistream_snooper;
   localparam int SW = 32;
   localparam int AW = 3;
   localparam int IW = 2;
   localparam int DW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rdy_for_sn;
   logic [AW-1:0] sn_addr;
   logic [SW-1:0] sn_wr_data;
   logic          sn_wr_en;
   logic [IW-1:0] sn_byte_inc;
   logic          sn_done;
   logic          packet_dropped;
   logic [DW-1:0] drop_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   axistream_snooper_if #(.SN_WIDTH(SW)) snoop_if ();

   axistream_snooper #(
      .SN_WIDTH       (SW),
      .ADDR_WIDTH     (AW),
      .INC_WIDTH      (IW),
      .DROP_CNT_WIDTH (DW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .snoop          (snoop_if),
      .rdy_for_sn     (rdy_for_sn),
      .sn_addr        (sn_addr),
      .sn_wr_data     (sn_wr_data),
      .sn_wr_en       (sn_wr_en),
      .sn_byte_inc    (sn_byte_inc),
      .sn_done        (sn_done),
      .packet_dropped (packet_dropped),
      .drop_cnt       (drop_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of link activity, then land 1ns after the edge that samples it
   task automatic step(input logic v, input logic r, input logic last,
                       input logic [3:0] keep, input logic [31:0] d);
      snoop_if.TVALID = v;
      snoop_if.TREADY = r;
      snoop_if.TLAST  = last;
      snoop_if.TKEEP  = keep;
      snoop_if.TDATA  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
   endtask

   task automatic expw(input string tag, input logic en, input logic [AW-1:0] addr,
                       input logic done, input logic [IW-1:0] inc, input logic [31:0] d);
      check({tag, ".en"}, sn_wr_en, en);
      check({tag, ".done"}, sn_done, done);
      if (en) begin
         check({tag, ".addr"}, sn_addr, addr);
         check({tag, ".inc"}, sn_byte_inc, inc);
         check({tag, ".data"}, sn_wr_data, d);
      end
   endtask

   initial begin
      rdy_for_sn      = 1'b1;
      snoop_if.TVALID = 1'b0;
      snoop_if.TREADY = 1'b0;
      snoop_if.TLAST  = 1'b0;
      snoop_if.TKEEP  = 4'h0;
      snoop_if.TDATA  = 32'h0;

      #12;
      check("rst.addr", sn_addr, 0);
      check("rst.data", sn_wr_data, 0);
      check("rst.en", sn_wr_en, 0);
      check("rst.inc", sn_byte_inc, 0);
      check("rst.done", sn_done, 0);
      check("rst.drop", packet_dropped, 0);
      check("rst.cnt", drop_cnt, 0);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // 3-beat packet, partial last word
      step(1, 1, 0, 4'hF, 32'h1111_0000); expw("p1b0", 1, 0, 0, 0, 32'h1111_0000);
      step(1, 1, 0, 4'hF, 32'h1111_0001); expw("p1b1", 1, 1, 0, 0, 32'h1111_0001);
      step(1, 1, 1, 4'hC, 32'h1111_0002); expw("p1b2", 1, 2, 1, 2, 32'h1111_0002);
      idle();                             expw("p1idle", 0, 0, 0, 0, 0);

      // No buffer at SOP: whole 4-beat packet dropped
      rdy_for_sn = 1'b0;
      step(1, 1, 0, 4'hF, 32'h2222_0000); expw("p2b0", 0, 0, 0, 0, 0);
      check("p2.drop0", packet_dropped, 1);
      check("p2.cnt", drop_cnt, 1);
      rdy_for_sn = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step(1, 1, i == 3, 4'hF, 32'h2222_0000 + i);
         expw("p2bn", 0, 0, 0, 0, 0);
         check("p2.dropn", packet_dropped, 0);
      end
      step(1, 1, 1, 4'hF, 32'h3333_0000); expw("p3b0", 1, 0, 1, 0, 32'h3333_0000);
      idle();

      // 12-beat packet overflows the 8-word buffer
      for (int i = 0; i < 12; i++) begin
         step(1, 1, i == 11, 4'hF, 32'h4444_0000 + i);
         if (i < 8) expw("p4w", 1, AW'(i), i == 7, 0, 32'h4444_0000 + i);
         else       expw("p4x", 0, 0, 0, 0, 0);
         check("p4.drop", packet_dropped, 0);
      end
      check("p4.cnt", drop_cnt, 1);
      idle();
      step(1, 1, 0, 4'hF, 32'h5555_0000); expw("p5b0", 1, 0, 0, 0, 32'h5555_0000);
      step(1, 1, 1, 4'h8, 32'h5555_0001); expw("p5b1", 1, 1, 1, 1, 32'h5555_0001);
      idle();

      // TREADY low on alternate cycles: only handshaked beats are written
      for (int k = 0; k < 4; k++) begin
         step(1, 0, k == 3, 4'hF, 32'h6666_0000 + k); expw("p6stall", 0, 0, 0, 0, 0);
         step(1, 1, k == 3, 4'hF, 32'h6666_0000 + k);
         expw("p6acc", 1, AW'(k), k == 3, 0, 32'h6666_0000 + k);
      end
      idle();

      // SOP right after a done is dropped; one idle cycle later it is captured
      step(1, 1, 1, 4'hE, 32'h7777_0000); expw("p7", 1, 0, 1, 3, 32'h7777_0000);
      step(1, 1, 1, 4'hF, 32'h7777_0001); expw("p8", 0, 0, 0, 0, 0);
      check("p8.drop", packet_dropped, 1);
      check("p8.cnt", drop_cnt, 2);
      idle();
      step(1, 1, 1, 4'hF, 32'h7777_0002); expw("p9", 1, 0, 1, 0, 32'h7777_0002);
      idle();

      // Drop counter saturates at all-ones
      rdy_for_sn = 1'b0;
      step(1, 1, 1, 4'hF, 32'h8888_0000); check("sat.cnt3", drop_cnt, 3);
      step(1, 1, 1, 4'hF, 32'h8888_0001); check("sat.drop", packet_dropped, 1);
      check("sat.cnt_hold", drop_cnt, 3);
      rdy_for_sn = 1'b1;
      idle();

      // Reset mid-packet at address 5
      for (int i = 0; i < 6; i++) step(1, 1, 0, 4'hF, 32'h9999_0000 + i);
      expw("p10b5", 1, 5, 0, 0, 32'h9999_0005);
      #2 rst = 1'b0;
      #1;
      check("mid.en", sn_wr_en, 0);
      check("mid.addr", sn_addr, 0);
      check("mid.data", sn_wr_data, 0);
      check("mid.done", sn_done, 0);
      check("mid.cnt", drop_cnt, 0);
      idle();
      #3 rst = 1'b1;
      step(1, 1, 0, 4'hF, 32'hAAAA_0000); expw("p11b0", 1, 0, 0, 0, 32'hAAAA_0000);
      step(1, 1, 1, 4'hF, 32'hAAAA_0001); expw("p11b1", 1, 1, 1, 0, 32'hAAAA_0001);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
